// File: rtl/strassen_pkg.sv
// Shared constants and types for the 2x2 Strassen block-multiply sequencer.
package strassen_pkg;

  // Block slice positions inside a packed 2x2 matrix
  localparam int BLK_11 = 0;
  localparam int BLK_12 = 1;
  localparam int BLK_21 = 2;
  localparam int BLK_22 = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    COMB = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic [2:0] M1 = 3'd0;
  localparam logic [2:0] M2 = 3'd1;
  localparam logic [2:0] M3 = 3'd2;
  localparam logic [2:0] M4 = 3'd3;
  localparam logic [2:0] M5 = 3'd4;
  localparam logic [2:0] M6 = 3'd5;
  localparam logic [2:0] M7 = 3'd6;

  localparam int NUM_PROD = 7;

endpackage

// File: rtl/strassen_operand_sel.sv
// Combinational Strassen pre-add: selects the operand pair for product M1..M7
// from the latched A and B blocks. All arithmetic wraps modulo 2^BLOCKSIZE.
module strassen_operand_sel
  import strassen_pkg::*;
#(
  parameter int BLOCKSIZE = 32,
  parameter int DATAWIDTH = 4 * BLOCKSIZE
) (
  input  logic [DATAWIDTH-1:0] a,
  input  logic [DATAWIDTH-1:0] b,
  input  logic [2:0]           prod_idx,
  output logic [BLOCKSIZE-1:0] op_a,
  output logic [BLOCKSIZE-1:0] op_b
);

  logic signed [BLOCKSIZE-1:0] a11, a12, a21, a22;
  logic signed [BLOCKSIZE-1:0] b11, b12, b21, b22;

  assign a11 = a[BLK_11*BLOCKSIZE +: BLOCKSIZE];
  assign a12 = a[BLK_12*BLOCKSIZE +: BLOCKSIZE];
  assign a21 = a[BLK_21*BLOCKSIZE +: BLOCKSIZE];
  assign a22 = a[BLK_22*BLOCKSIZE +: BLOCKSIZE];
  assign b11 = b[BLK_11*BLOCKSIZE +: BLOCKSIZE];
  assign b12 = b[BLK_12*BLOCKSIZE +: BLOCKSIZE];
  assign b21 = b[BLK_21*BLOCKSIZE +: BLOCKSIZE];
  assign b22 = b[BLK_22*BLOCKSIZE +: BLOCKSIZE];

  always_comb begin
    op_a = '0;
    op_b = '0;
    case (prod_idx)
      M1: begin
        op_a = a11 + a22;
        op_b = b11 + b22;
      end
      M2: begin
        op_a = a21 + a22;
        op_b = b11;
      end
      M3: begin
        op_a = a11;
        op_b = b12 - b22;
      end
      M4: begin
        op_a = a22;
        op_b = b21 - b11;
      end
      M5: begin
        op_a = a11 + a12;
        op_b = b22;
      end
      M6: begin
        op_a = a21 - a11;
        op_b = b11 + b12;
      end
      M7: begin
        op_a = a12 - a22;
        op_b = b21 + b22;
      end
      default: begin
        op_a = '0;
        op_b = '0;
      end
    endcase
  end

endmodule

// File: rtl/strassen_seq_ctrl.sv
// Sequencer for one 2x2 Strassen block multiply: issues the seven products to a
// shared external multiplier over req/ack, then combines them into C.
module strassen_seq_ctrl
  import strassen_pkg::*;
#(
  parameter int BLOCKSIZE = 32,
  parameter int DATAWIDTH = 4 * BLOCKSIZE
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [DATAWIDTH-1:0] A,
  input  logic [DATAWIDTH-1:0] B,
  output logic                 mul_req,
  output logic [BLOCKSIZE-1:0] mul_a,
  output logic [BLOCKSIZE-1:0] mul_b,
  input  logic                 mul_ack,
  input  logic [BLOCKSIZE-1:0] mul_p,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [DATAWIDTH-1:0] C,
  output logic                 busy,
  output logic [2:0]           prod_idx
);

  state_t                      state_q, state_d;
  logic [2:0]                  prod_idx_q, prod_idx_d;
  logic [DATAWIDTH-1:0]        a_q, a_d, b_q, b_d;
  logic signed [BLOCKSIZE-1:0] m_q [NUM_PROD];
  logic signed [BLOCKSIZE-1:0] m_d [NUM_PROD];
  logic [BLOCKSIZE-1:0]        mul_a_q, mul_a_d, mul_b_q, mul_b_d;
  logic [BLOCKSIZE-1:0]        sel_a, sel_b;
  logic [DATAWIDTH-1:0]        c_q, c_d;
  logic signed [BLOCKSIZE-1:0] c11, c12, c21, c22;

  // Operands are selected from next-state values so the registered pair is
  // already valid in the first MUL cycle and in the cycle after each ack.
  strassen_operand_sel #(
    .BLOCKSIZE(BLOCKSIZE),
    .DATAWIDTH(DATAWIDTH)
  ) u_operand_sel (
    .a       (a_d),
    .b       (b_d),
    .prod_idx(prod_idx_d),
    .op_a    (sel_a),
    .op_b    (sel_b)
  );

  assign c11 = m_q[M1] + m_q[M4] - m_q[M5] + m_q[M7];
  assign c12 = m_q[M3] + m_q[M5];
  assign c21 = m_q[M2] + m_q[M4];
  assign c22 = m_q[M1] - m_q[M2] + m_q[M3] + m_q[M6];

  always_comb begin
    state_d    = state_q;
    prod_idx_d = prod_idx_q;
    a_d        = a_q;
    b_d        = b_q;
    c_d        = c_q;
    for (int k = 0; k < NUM_PROD; k++) begin
      m_d[k] = m_q[k];
    end

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d        = A;
          b_d        = B;
          prod_idx_d = M1;
          state_d    = MUL;
        end
      end
      MUL: begin
        if (mul_ack) begin
          for (int k = 0; k < NUM_PROD; k++) begin
            if (prod_idx_q == k[2:0]) m_d[k] = mul_p;
          end
          if (prod_idx_q == M7) state_d = COMB;
          else                  prod_idx_d = prod_idx_q + 3'd1;
        end
      end
      COMB: begin
        c_d     = {c22, c21, c12, c11};
        state_d = DONE;
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    mul_a_d = (state_d == MUL) ? sel_a : '0;
    mul_b_d = (state_d == MUL) ? sel_b : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      prod_idx_q <= '0;
      a_q        <= '0;
      b_q        <= '0;
      mul_a_q    <= '0;
      mul_b_q    <= '0;
      c_q        <= '0;
      for (int k = 0; k < NUM_PROD; k++) begin
        m_q[k] <= '0;
      end
    end else begin
      state_q    <= state_d;
      prod_idx_q <= prod_idx_d;
      a_q        <= a_d;
      b_q        <= b_d;
      mul_a_q    <= mul_a_d;
      mul_b_q    <= mul_b_d;
      c_q        <= c_d;
      for (int k = 0; k < NUM_PROD; k++) begin
        m_q[k] <= m_d[k];
      end
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign mul_req   = (state_q == MUL);
  assign out_valid = (state_q == DONE);
  assign mul_a     = mul_a_q;
  assign mul_b     = mul_b_q;
  assign C         = c_q;
  assign prod_idx  = prod_idx_q;

endmodule

// File: tb/tb_strassen_seq_ctrl.sv
// Scoreboard bench for strassen_seq_ctrl: a 32-bit instance driven through
// directed transactions and an 8-bit instance exercising modular wrap.
module tb_strassen_seq_ctrl;

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] A, B, C;
  logic         mul_req, mul_ack;
  logic [31:0]  mul_a, mul_b, mul_p;
  logic         out_valid, out_ready, busy;
  logic [2:0]   prod_idx;

  logic         in_valid8, in_ready8, mul_req8, mul_ack8;
  logic [31:0]  A8, B8, C8;
  logic [7:0]   mul_a8, mul_b8, mul_p8;
  logic         out_valid8, out_ready8, busy8;
  logic [2:0]   prod_idx8;

  int n_chk;
  int n_fail;
  logic [127:0] sb_q[$];
  logic [31:0]  sb8_q[$];
  logic [31:0]  req_a[7];
  logic [31:0]  req_b[7];

  strassen_seq_ctrl #(.BLOCKSIZE(32)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .A(A), .B(B),
    .mul_req(mul_req), .mul_a(mul_a), .mul_b(mul_b), .mul_ack(mul_ack), .mul_p(mul_p),
    .out_valid(out_valid), .out_ready(out_ready), .C(C), .busy(busy), .prod_idx(prod_idx)
  );

  strassen_seq_ctrl #(.BLOCKSIZE(8)) dut8 (
    .clk(clk), .rst(rst), .in_valid(in_valid8), .in_ready(in_ready8), .A(A8), .B(B8),
    .mul_req(mul_req8), .mul_a(mul_a8), .mul_b(mul_b8), .mul_ack(mul_ack8), .mul_p(mul_p8),
    .out_valid(out_valid8), .out_ready(out_ready8), .C(C8), .busy(busy8), .prod_idx(prod_idx8)
  );

  // External multiplier model: product of the presented operands, truncated
  assign mul_p    = mul_a * mul_b;
  assign mul_p8   = mul_a8 * mul_b8;
  assign mul_ack8 = 1'b1;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [127:0] ref_mul(input logic [127:0] a, input logic [127:0] b);
    logic [31:0] x[4];
    logic [31:0] y[4];
    logic [31:0] c[4];
    for (int k = 0; k < 4; k++) begin
      x[k] = a[k*32 +: 32];
      y[k] = b[k*32 +: 32];
    end
    c[0] = x[0] * y[0] + x[1] * y[2];
    c[1] = x[0] * y[1] + x[1] * y[3];
    c[2] = x[2] * y[0] + x[3] * y[2];
    c[3] = x[2] * y[1] + x[3] * y[3];
    return {c[3], c[2], c[1], c[0]};
  endfunction

  function automatic logic [31:0] ref_mul8(input logic [31:0] a, input logic [31:0] b);
    logic [7:0] x[4];
    logic [7:0] y[4];
    logic [7:0] c[4];
    for (int k = 0; k < 4; k++) begin
      x[k] = a[k*8 +: 8];
      y[k] = b[k*8 +: 8];
    end
    c[0] = x[0] * y[0] + x[1] * y[2];
    c[1] = x[0] * y[1] + x[1] * y[3];
    c[2] = x[2] * y[0] + x[3] * y[2];
    c[3] = x[2] * y[1] + x[3] * y[3];
    return {c[3], c[2], c[1], c[0]};
  endfunction

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_in_ready"},  in_ready,  1);
    chk({tag, "_mul_req"},   mul_req,   0);
    chk({tag, "_mul_a"},     mul_a,     0);
    chk({tag, "_mul_b"},     mul_b,     0);
    chk({tag, "_out_valid"}, out_valid, 0);
    chk({tag, "_C"},         C,         0);
    chk({tag, "_busy"},      busy,      0);
    chk({tag, "_prod_idx"},  prod_idx,  0);
  endtask

  // One full transaction. stall_idx/stall_n: hold ack low for stall_n cycles at
  // that product; out_stall: cycles of out_ready low in DONE; keep_valid keeps
  // in_valid asserted for the whole transaction.
  task automatic run_txn(input string tag, input logic [127:0] a, input logic [127:0] b,
                         input int stall_idx, input int stall_n, input int out_stall,
                         input bit keep_valid, input int exp_lat);
    int cyc;
    int seen;
    logic [31:0]  ra, rb;
    logic [127:0] c_seen, exp;
    sb_q.push_back(ref_mul(a, b));
    A = a;
    B = b;
    in_valid = 1'b1;
    chk({tag, "_accept_ready"}, in_ready, 1);
    tick();
    in_valid = keep_valid;
    cyc  = 1;
    seen = 0;
    ra   = '0;
    rb   = '0;
    while (!out_valid && cyc < 100) begin
      mul_ack = 1'b1;
      if (mul_req && int'(prod_idx) == stall_idx) begin
        seen++;
        if (seen == 1) begin
          ra = mul_a;
          rb = mul_b;
        end else begin
          chk({tag, "_stall_mul_a"}, mul_a, ra);
          chk({tag, "_stall_mul_b"}, mul_b, rb);
          chk({tag, "_stall_req"}, mul_req, 1);
        end
        mul_ack = (seen > stall_n);
      end
      if (mul_req && mul_ack) begin
        req_a[prod_idx] = mul_a;
        req_b[prod_idx] = mul_b;
      end
      tick();
      cyc++;
    end
    mul_ack = 1'b0;
    if (cyc >= 100) chk({tag, "_timeout"}, 0, 1);
    chk({tag, "_latency"}, cyc, exp_lat);
    if (stall_n > 0) chk({tag, "_stall_cycles"}, seen, stall_n + 1);
    c_seen = C;
    for (int i = 0; i < out_stall; i++) begin
      out_ready = 1'b0;
      chk({tag, "_hold_valid"}, out_valid, 1);
      chk({tag, "_hold_C"}, C, c_seen);
      chk({tag, "_hold_in_ready"}, in_ready, 0);
      tick();
    end
    if (sb_q.size() == 0) begin
      chk({tag, "_sb_empty"}, 0, 1);
    end else begin
      exp = sb_q.pop_front();
      chk({tag, "_C"}, C, exp);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk({tag, "_post_out_valid"}, out_valid, 0);
    chk({tag, "_post_in_ready"}, in_ready, 1);
  endtask

  logic [127:0] va, vb, ia, ib;

  initial begin
    n_chk      = 0;
    n_fail     = 0;
    rst        = 1'b1;
    in_valid   = 1'b0;
    A          = '0;
    B          = '0;
    mul_ack    = 1'b0;
    out_ready  = 1'b0;
    in_valid8  = 1'b0;
    A8         = '0;
    B8         = '0;
    out_ready8 = 1'b0;
    va = {32'd4, 32'd3, 32'd2, 32'd1};
    vb = {32'd8, 32'd7, 32'd6, 32'd5};
    ia = {32'd1, 32'd0, 32'd0, 32'd1};
    ib = {32'd6, 32'd7, 32'd8, 32'd9};
    tick();
    tick();
    chk_reset_outputs("reset");
    rst = 1'b0;
    tick();

    // Test 1: directed multiply, ack always high
    run_txn("t1", va, vb, -1, 0, 0, 1'b0, 9);
    chk("t1_first_a", req_a[0], 32'd5);
    chk("t1_first_b", req_b[0], 32'd13);
    chk("t1_C_const", C, {32'd50, 32'd43, 32'd22, 32'd19});

    // Test 2: identity with negative intermediates
    run_txn("t2", ia, ib, -1, 0, 0, 1'b0, 9);
    chk("t2_m4_b", req_b[3], 32'hFFFF_FFFE);
    chk("t2_C_const", C, ib);

    // Test 4: multiplier backpressure on M3
    run_txn("t4", {32'hFFFF_FFF0, 32'd77, 32'h8000_0001, 32'd123},
            {32'd9, 32'hDEAD_BEEF, 32'd3, 32'hFFFF_FFFF}, 2, 3, 0, 1'b0, 12);

    // Test 5: output backpressure with in_valid held high, then back-to-back accept
    run_txn("t5", va, vb, -1, 0, 5, 1'b1, 9);
    run_txn("t5b", ia, ib, -1, 0, 0, 1'b0, 9);

    // Test 6: reset mid-operation at prod_idx 3, then a stray ack
    A = va;
    B = vb;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    begin
      int guard;
      guard = 0;
      while (prod_idx != 3'd3 && guard < 50) begin
        mul_ack = 1'b1;
        tick();
        guard++;
      end
      if (guard >= 50) chk("t6_reach_idx3", 0, 1);
    end
    chk("t6_idx3", prod_idx, 3);
    mul_ack = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk_reset_outputs("t6_rst");
    mul_ack = 1'b1;
    tick();
    mul_ack = 1'b0;
    chk("t6_stray_busy", busy, 0);
    chk("t6_stray_req", mul_req, 0);
    chk("t6_stray_idx", prod_idx, 0);
    chk("t6_stray_out_valid", out_valid, 0);
    run_txn("t6", va, vb, -1, 0, 0, 1'b0, 9);
    chk("t6_C_const", C, {32'd50, 32'd43, 32'd22, 32'd19});

    // Test 3: 8-bit instance, M1 operand a wraps to 44
    A8 = {8'd100, 8'd7, 8'd3, 8'd200};
    B8 = {8'd9, 8'd250, 8'd17, 8'd123};
    sb8_q.push_back(ref_mul8(A8, B8));
    in_valid8 = 1'b1;
    chk("t3_accept_ready", in_ready8, 1);
    tick();
    in_valid8 = 1'b0;
    chk("t3_m1_req", mul_req8, 1);
    chk("t3_m1_a", mul_a8, 8'd44);
    begin
      int guard;
      guard = 0;
      while (!out_valid8 && guard < 50) begin
        tick();
        guard++;
      end
      if (guard >= 50) chk("t3_timeout", 0, 1);
    end
    if (sb8_q.size() == 0) chk("t3_sb_empty", 0, 1);
    else chk("t3_C", C8, sb8_q.pop_front());
    out_ready8 = 1'b1;
    tick();
    out_ready8 = 1'b0;
    chk("t3_post_in_ready", in_ready8, 1);

    chk("sb_drained", sb_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
